ex_forwarding_unit: RTL and testbench

EX_FORWARDING_UNIT -- requirements
Module: ex_forwarding_unit

---
 rtl/ex_forwarding_unit.sv | 122 ++++++++++++
 tb/tb_ex_forwarding_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ex_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_forwarding_unit
// Description : EX-stage operand forwarding selects for an RV32I pipeline,
//               plus saturating MEM/WB forwarding event counters.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_forwarding_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       EX_opcode,
    input  logic             WB_cntl_RegWrite,
    input  logic             MEM_cntl_RegWrite,
    input  logic [4:0]       WB_WriteRegNum,
    input  logic [4:0]       MEM_WriteRegNum,
    input  logic [4:0]       EX_ReadRegNum1,
    input  logic [4:0]       EX_ReadRegNum2,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] FwdMemCount,
    output logic [CNT_W-1:0] FwdWbCount
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             use_rs1;
    logic             use_rs2;
    logic             mem_valid;
    logic             wb_valid;
    logic             mem_hit_d;
    logic             wb_hit_d;
    logic [CNT_W-1:0] mem_cnt_d;
    logic [CNT_W-1:0] wb_cnt_d;
    logic [CNT_W-1:0] mem_cnt_q;
    logic [CNT_W-1:0] wb_cnt_q;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (EX_opcode)
            OP_RTYPE, OP_STORE, OP_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_ITYPE, OP_LOAD, OP_JALR: begin
                use_rs1 = 1'b1;
            end
            default: begin
                use_rs1 = 1'b0;
                use_rs2 = 1'b0;
            end
        endcase
    end

    // x0 is hardwired to zero, so a pending write to it never produces a value.
    assign mem_valid = MEM_cntl_RegWrite && (MEM_WriteRegNum != 5'd0);
    assign wb_valid  = WB_cntl_RegWrite  && (WB_WriteRegNum  != 5'd0);

    always_comb begin
        ForwardA = FWD_RF;
        if (use_rs1) begin
            if (mem_valid && (MEM_WriteRegNum == EX_ReadRegNum1)) begin
                ForwardA = FWD_MEM;
            end else if (wb_valid && (WB_WriteRegNum == EX_ReadRegNum1)) begin
                ForwardA = FWD_WB;
            end
        end
    end

    always_comb begin
        ForwardB = FWD_RF;
        if (use_rs2) begin
            if (mem_valid && (MEM_WriteRegNum == EX_ReadRegNum2)) begin
                ForwardB = FWD_MEM;
            end else if (wb_valid && (WB_WriteRegNum == EX_ReadRegNum2)) begin
                ForwardB = FWD_WB;
            end
        end
    end

    assign mem_hit_d = (ForwardA == FWD_MEM) || (ForwardB == FWD_MEM);
    assign wb_hit_d  = (ForwardA == FWD_WB)  || (ForwardB == FWD_WB);

    always_comb begin
        mem_cnt_d = mem_cnt_q;
        wb_cnt_d  = wb_cnt_q;
        if (mem_hit_d && (mem_cnt_q != CNT_MAX)) begin
            mem_cnt_d = mem_cnt_q + 1'b1;
        end
        if (wb_hit_d && (wb_cnt_q != CNT_MAX)) begin
            wb_cnt_d = wb_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_cnt_q <= '0;
            wb_cnt_q  <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

    assign FwdMemCount = mem_cnt_q;
    assign FwdWbCount  = wb_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_forwarding_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_forwarding_unit
// Description : Directed self-checking bench for ex_forwarding_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_forwarding_unit;

    logic        clk;
    logic        reset;
    logic [6:0]  EX_opcode;
    logic        WB_cntl_RegWrite;
    logic        MEM_cntl_RegWrite;
    logic [4:0]  WB_WriteRegNum;
    logic [4:0]  MEM_WriteRegNum;
    logic [4:0]  EX_ReadRegNum1;
    logic [4:0]  EX_ReadRegNum2;
    logic [1:0]  ForwardA;
    logic [1:0]  ForwardB;
    logic [15:0] FwdMemCount;
    logic [15:0] FwdWbCount;
    logic [1:0]  ForwardA_s;
    logic [1:0]  ForwardB_s;
    logic [1:0]  FwdMemCount_s;
    logic [1:0]  FwdWbCount_s;

    int n_cmp = 0;
    int n_err = 0;

    ex_forwarding_unit #(.CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .EX_opcode        (EX_opcode),
        .WB_cntl_RegWrite (WB_cntl_RegWrite),
        .MEM_cntl_RegWrite(MEM_cntl_RegWrite),
        .WB_WriteRegNum   (WB_WriteRegNum),
        .MEM_WriteRegNum  (MEM_WriteRegNum),
        .EX_ReadRegNum1   (EX_ReadRegNum1),
        .EX_ReadRegNum2   (EX_ReadRegNum2),
        .ForwardA         (ForwardA),
        .ForwardB         (ForwardB),
        .FwdMemCount      (FwdMemCount),
        .FwdWbCount       (FwdWbCount)
    );

    ex_forwarding_unit #(.CNT_W(2)) dut_small (
        .clk              (clk),
        .reset            (reset),
        .EX_opcode        (EX_opcode),
        .WB_cntl_RegWrite (WB_cntl_RegWrite),
        .MEM_cntl_RegWrite(MEM_cntl_RegWrite),
        .WB_WriteRegNum   (WB_WriteRegNum),
        .MEM_WriteRegNum  (MEM_WriteRegNum),
        .EX_ReadRegNum1   (EX_ReadRegNum1),
        .EX_ReadRegNum2   (EX_ReadRegNum2),
        .ForwardA         (ForwardA_s),
        .ForwardB         (ForwardB_s),
        .FwdMemCount      (FwdMemCount_s),
        .FwdWbCount       (FwdWbCount_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] op, input logic wrw, input logic mrw,
                         input logic [4:0] wn, input logic [4:0] mn,
                         input logic [4:0] r1, input logic [4:0] r2);
        EX_opcode         = op;
        WB_cntl_RegWrite  = wrw;
        MEM_cntl_RegWrite = mrw;
        WB_WriteRegNum    = wn;
        MEM_WriteRegNum   = mn;
        EX_ReadRegNum1    = r1;
        EX_ReadRegNum2    = r2;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(7'b0110011, 1'b0, 1'b0, 5'd1, 5'd2, 5'd3, 5'd4);
        chk("rst_mem_cnt", int'(FwdMemCount), 0);
        chk("rst_wb_cnt", int'(FwdWbCount), 0);

        // Selects are checked with reset held high: they must not depend on it.
        chk("none_A", int'(ForwardA), 0);
        chk("none_B", int'(ForwardB), 0);

        drive(7'b0110011, 1'b1, 1'b0, 5'd3, 5'd2, 5'd3, 5'd4);
        chk("wb_rs1_A", int'(ForwardA), 1);
        chk("wb_rs1_B", int'(ForwardB), 0);

        drive(7'b0110011, 1'b1, 1'b0, 5'd4, 5'd2, 5'd3, 5'd4);
        chk("wb_rs2_A", int'(ForwardA), 0);
        chk("wb_rs2_B", int'(ForwardB), 1);

        drive(7'b0110011, 1'b0, 1'b1, 5'd1, 5'd3, 5'd3, 5'd4);
        chk("mem_rs1_A", int'(ForwardA), 2);
        chk("mem_rs1_B", int'(ForwardB), 0);

        drive(7'b0110011, 1'b0, 1'b1, 5'd1, 5'd4, 5'd3, 5'd4);
        chk("mem_rs2_A", int'(ForwardA), 0);
        chk("mem_rs2_B", int'(ForwardB), 2);

        drive(7'b0110011, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 5'd4);
        chk("prio_A", int'(ForwardA), 2);
        chk("prio_B", int'(ForwardB), 0);

        drive(7'b0110011, 1'b0, 1'b1, 5'd1, 5'd0, 5'd0, 5'd4);
        chk("x0_mem_A", int'(ForwardA), 0);

        drive(7'b0110011, 1'b1, 1'b0, 5'd0, 5'd2, 5'd0, 5'd4);
        chk("x0_wb_A", int'(ForwardA), 0);

        drive(7'b0010011, 1'b0, 1'b1, 5'd1, 5'd4, 5'd3, 5'd4);
        chk("itype_A", int'(ForwardA), 0);
        chk("itype_B", int'(ForwardB), 0);

        drive(7'b0110111, 1'b1, 1'b1, 5'd4, 5'd3, 5'd3, 5'd4);
        chk("lui_A", int'(ForwardA), 0);
        chk("lui_B", int'(ForwardB), 0);

        drive(7'b0100011, 1'b0, 1'b1, 5'd1, 5'd5, 5'd5, 5'd5);
        chk("store_same_A", int'(ForwardA), 2);
        chk("store_same_B", int'(ForwardB), 2);

        drive(7'b1100111, 1'b1, 1'b1, 5'd3, 5'd4, 5'd3, 5'd4);
        chk("jalr_A", int'(ForwardA), 1);
        chk("jalr_B", int'(ForwardB), 0);

        // Counter phase: MEM match on rs1 for 5 edges.
        @(negedge clk);
        drive(7'b0110011, 1'b0, 1'b1, 5'd1, 5'd3, 5'd3, 5'd4);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("cnt5_mem", int'(FwdMemCount), 5);
        chk("cnt5_wb", int'(FwdWbCount), 0);

        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("async_rst_mem", int'(FwdMemCount), 0);
        chk("async_rst_wb", int'(FwdWbCount), 0);
        chk("async_rst_small", int'(FwdMemCount_s), 0);
        chk("rst_keeps_A", int'(ForwardA), 2);

        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_hold", int'(FwdMemCount), 0);
        @(posedge clk);
        #1;
        chk("resume_mem", int'(FwdMemCount), 1);

        // Both operands from MEM still count once per cycle.
        @(negedge clk);
        drive(7'b0110011, 1'b0, 1'b1, 5'd1, 5'd3, 5'd3, 5'd3);
        repeat (5) @(posedge clk);
        #1;
        chk("once_per_cycle", int'(FwdMemCount), 6);
        chk("sat_small_mem", int'(FwdMemCount_s), 3);

        @(negedge clk);
        drive(7'b0110011, 1'b1, 1'b1, 5'd4, 5'd3, 5'd3, 5'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("mix_mem", int'(FwdMemCount), 8);
        chk("mix_wb", int'(FwdWbCount), 2);
        chk("mix_small_wb", int'(FwdWbCount_s), 2);
        chk("mix_small_mem", int'(FwdMemCount_s), 3);

        @(negedge clk);
        drive(7'b0110111, 1'b1, 1'b1, 5'd4, 5'd3, 5'd3, 5'd4);
        @(posedge clk);
        #1;
        chk("lui_no_cnt_mem", int'(FwdMemCount), 8);
        chk("lui_no_cnt_wb", int'(FwdWbCount), 2);

        @(negedge clk);
        drive(7'b0110011, 1'b1, 1'b0, 5'd4, 5'd3, 5'd3, 5'd4);
        repeat (2) @(posedge clk);
        #1;
        chk("sat_small_wb", int'(FwdWbCount_s), 3);
        chk("wb_cnt_16", int'(FwdWbCount), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
